alu_operand_mux_pipe: RTL and testbench
=======================================

Name: alu_operand_mux_pipe

Overview:
- Parametrised, registered successor to the ALU operand-byte input mux. Holds a DEPTH-entry history of fetched operand bytes: entry 0 is OP, entry 1 is OPold, and older entries follow.
- Builds the ALU Low (2W) and High (W) operand words from a mode code, then presents them through a one-deep output register with a valid/ready handshake.
- Sits on the register board, between operand fetch and the ALU A/B input selectors.

Parameters:
- W, 8, operand byte width; Low is 2W wide and High is W wide.
- DEPTH, 4, number of history entries (OP, OPold, OPold2, ...); legal range 2..16.
- IDX_W, 2, width of hist_idx; must be at least clog2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- notRST  in  1  asynchronous reset, active-low.
- notDin  in  W  incoming operand byte, active-low (same polarity as the fetch bus).
- din_load  in  1  shifts the history: hist[k] <= hist[k-1], hist[0] <= ~notDin.
- hist_clr  in  1  synchronous clear of all history entries to 0; takes priority over din_load.
- req_valid  in  1  a mux request is presented.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- low_sel  in  3  Low mode code (see Behaviour).
- high_sel  in  1  High = OP when 1, 0 when 0.
- hist_idx  in  IDX_W  history entry used by the SEL_HIST mode.
- out_valid  out  1  Low, High and out_err hold a result.
- out_ready  in  1  consumer takes the result.
- Low  out  2W  registered Low operand.
- High  out  W  registered High operand.
- out_err  out  1  registered flag: request used an illegal code or index.

Behaviour:
- Reset (notRST=0, asynchronous): all hist = 0, out_valid = 0, Low = 0, High = 0, out_err = 0. Reset mid-transfer drops the pending result.
- History is stored in true polarity (inverted from notDin). Priority each cycle: hist_clr over din_load over hold.
- Accept condition: accept = req_valid & req_ready, with req_ready = ~out_valid | out_ready (combinational).
- Latency: on the accepting edge the result registers load, and out_valid = 1 from the next cycle.
- While out_valid & ~out_ready: Low, High and out_err hold stable, and req_ready = 0.
- If out_valid & out_ready & ~accept, out_valid falls to 0.
- Back-to-back transfers give one result per cycle.
- On a same-cycle accept and din_load/hist_clr, the result is computed from the pre-update history (the values before the edge).
- low_sel codes (OP = hist[0], OPold = hist[1]):
  - 0 ZERO: Low = 0.
  - 1 OP: Low = {0, OP}.
  - 2 FF_OP: Low = {all ones (W bits), OP}.
  - 3 OP_OPOLD: Low = {OP, OPold}.
  - 4 OPOLD: Low = {0, OPold}.
  - 5 HIST: Low = {0, hist[hist_idx]}.
  - 6 HIST_OP: Low = {OP, hist[hist_idx]}.
  - 7 reserved.
- Illegal requests: low_sel = 7, or hist_idx >= DEPTH with low_sel in {5, 6}. The result is Low = 0 and High computed normally, with out_err = 1 for that result only (not sticky).
- High = high_sel ? OP : 0, independent of low_sel.
- Output hold: when no accept occurs, Low, High and out_err keep their last values even with out_valid = 0.
- The history never wraps: the oldest entry is discarded on shift.

Test Plan (W=8, DEPTH=4):
- Reset, then notRST=1. Load notDin=0xA5, then 0x3C. Request low_sel=3, high_sel=1, out_ready=1 → next cycle out_valid=1, Low=0xC35A, High=0xC3, out_err=0.
- Hold out_ready=0 with a result pending; drive a new request → req_ready=0, Low held, second request accepted the cycle after out_ready rises.
- Load 0xEF, 0xDE, 0xAD, 0xBE, 0x0F (true values 0x10, 0x21, 0x52, 0x41, 0xF0). Request low_sel=5, hist_idx=3 → Low=0x0021; hist_idx=0 → Low=0x00F0.
- Same-cycle din_load (notDin=0x00) and accept with low_sel=1, OP=0x12 → Low=0x0012; the following request gives Low=0x00FF.
- low_sel=7 → Low=0, out_err=1; next legal request has out_err=0. DEPTH=3 build with hist_idx=3 → out_err=1.
- Assert notRST=0 while out_valid=1 and out_ready=0 → out_valid, Low, High and all history clear immediately (asynchronously). hist_clr together with din_load → history is all 0.

Source files
------------

// File: rtl/alu_operand_mux_pipe.sv
// -----------------------------------------------------------------------------
// alu_operand_mux_pipe
//
// This block keeps a short history of fetched operand bytes and builds the ALU
// Low (2W) and High (W) operand words from it. Each result is held in a
// one-deep output register that uses a valid/ready handshake.
//
// History: hist[0] is OP, hist[1] is OPold, and older entries follow. Bytes
// arrive active-low on notDin and are stored inverted, so the history holds
// true-polarity values. On each clock edge the history does one of three
// things, in this priority: hist_clr clears every entry, else din_load shifts,
// else it holds. A shift drops the oldest entry; the history never wraps.
//
// Handshake (valid/ready):
//   req_ready = ~out_valid | out_ready. A request is accepted on any rising
//   edge where req_valid & req_ready is high. On that edge Low, High and
//   out_err load the result, and out_valid is high from the next cycle.
//   The consumer takes the result on an edge where out_valid & out_ready is
//   high. While out_valid & ~out_ready, the outputs stay stable and
//   req_ready is low. When no accept occurs, Low, High and out_err keep their
//   last values, even after out_valid drops.
//
// The result always comes from the history as it stood before the edge. This
// holds even when the same edge also shifts or clears the history.
//
// Ports:
//   clk        system clock, rising edge
//   notRST     asynchronous reset, active-low
//   notDin     incoming operand byte, active-low
//   din_load   shift notDin (inverted) into the history
//   hist_clr   synchronous clear of the history (wins over din_load)
//   req_valid  request present          req_ready  request can be taken
//   low_sel    Low mode code            high_sel   High = OP when 1, else 0
//   hist_idx   history entry for the HIST / HIST_OP modes
//   out_valid  result present           out_ready  consumer takes the result
//   Low        registered Low word      High       registered High word
//   out_err    result came from an illegal code or index
// -----------------------------------------------------------------------------
module alu_operand_mux_pipe #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             notRST,
  input  logic [W-1:0]     notDin,
  input  logic             din_load,
  input  logic             hist_clr,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       low_sel,
  input  logic             high_sel,
  input  logic [IDX_W-1:0] hist_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   Low,
  output logic [W-1:0]     High,
  output logic             out_err
);

  localparam logic [2:0] SEL_ZERO     = 3'd0;
  localparam logic [2:0] SEL_OP       = 3'd1;
  localparam logic [2:0] SEL_FF_OP    = 3'd2;
  localparam logic [2:0] SEL_OP_OPOLD = 3'd3;
  localparam logic [2:0] SEL_OPOLD    = 3'd4;
  localparam logic [2:0] SEL_HIST     = 3'd5;
  localparam logic [2:0] SEL_HIST_OP  = 3'd6;

  logic [W-1:0]   hist [DEPTH];
  logic [W-1:0]   op;
  logic [W-1:0]   op_old;
  logic [W-1:0]   hist_pick;
  logic           idx_ok;
  logic [2*W-1:0] low_nxt;
  logic [W-1:0]   high_nxt;
  logic           err_nxt;
  logic           accept;

  // ---------------------------------------------------------------------------
  // Operand history
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge notRST) begin
    if (!notRST) begin
      for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
    end else if (hist_clr) begin
      for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
    end else if (din_load) begin
      hist[0] <= ~notDin;
      for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Result mux
  // ---------------------------------------------------------------------------
  // Scan the entries instead of indexing hist directly. An out-of-range
  // hist_idx then matches nothing, so idx_ok stays low and we never read past
  // the end of the array.
  always_comb begin
    op        = hist[0];
    op_old    = hist[1];
    hist_pick = '0;
    idx_ok    = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (hist_idx == IDX_W'(k)) begin
        hist_pick = hist[k];
        idx_ok    = 1'b1;
      end
    end
  end

  always_comb begin
    low_nxt  = '0;
    err_nxt  = 1'b0;
    high_nxt = high_sel ? op : '0;
    case (low_sel)
      SEL_ZERO:     low_nxt = '0;
      SEL_OP:       low_nxt = {{W{1'b0}}, op};
      SEL_FF_OP:    low_nxt = {{W{1'b1}}, op};
      SEL_OP_OPOLD: low_nxt = {op, op_old};
      SEL_OPOLD:    low_nxt = {{W{1'b0}}, op_old};
      SEL_HIST: begin
        low_nxt = idx_ok ? {{W{1'b0}}, hist_pick} : '0;
        err_nxt = ~idx_ok;
      end
      SEL_HIST_OP: begin
        low_nxt = idx_ok ? {op, hist_pick} : '0;
        err_nxt = ~idx_ok;
      end
      default: begin
        // Reserved code: Low forced to zero and the result is flagged.
        low_nxt = '0;
        err_nxt = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // One-deep output register
  // ---------------------------------------------------------------------------
  assign req_ready = ~out_valid | out_ready;
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk or negedge notRST) begin
    if (!notRST) begin
      out_valid <= 1'b0;
      Low       <= '0;
      High      <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      Low       <= low_nxt;
      High      <= high_nxt;
      out_err   <= err_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_mux_pipe.sv
module tb_alu_operand_mux_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         notRST;
  logic [W-1:0] notDin;
  logic         din_load, hist_clr, req_valid, high_sel, out_ready;
  logic [2:0]   low_sel;
  logic [1:0]   hist_idx;

  logic         req_ready, out_valid, out_err;
  logic [15:0]  Low;
  logic [7:0]   High;

  // DEPTH=3 instance on the same inputs, used for the out-of-range index case.
  logic         req_ready3, out_valid3, out_err3;
  logic [15:0]  Low3;
  logic [7:0]   High3;

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // clock / reset block
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  alu_operand_mux_pipe #(.W(8), .DEPTH(4), .IDX_W(2)) dut (
    .clk(clk), .notRST(notRST), .notDin(notDin), .din_load(din_load),
    .hist_clr(hist_clr), .req_valid(req_valid), .req_ready(req_ready),
    .low_sel(low_sel), .high_sel(high_sel), .hist_idx(hist_idx),
    .out_valid(out_valid), .out_ready(out_ready), .Low(Low), .High(High),
    .out_err(out_err)
  );

  alu_operand_mux_pipe #(.W(8), .DEPTH(3), .IDX_W(2)) dut3 (
    .clk(clk), .notRST(notRST), .notDin(notDin), .din_load(din_load),
    .hist_clr(hist_clr), .req_valid(req_valid), .req_ready(req_ready3),
    .low_sel(low_sel), .high_sel(high_sel), .hist_idx(hist_idx),
    .out_valid(out_valid3), .out_ready(out_ready), .Low(Low3), .High(High3),
    .out_err(out_err3)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    din_load = 1'b1;
    notDin   = b;
    tick();
    din_load = 1'b0;
  endtask

  task automatic idle_inputs();
    din_load  = 1'b0;
    hist_clr  = 1'b0;
    req_valid = 1'b0;
    low_sel   = 3'd0;
    high_sel  = 1'b0;
    hist_idx  = 2'd0;
    notDin    = 8'h00;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b1;
    notRST    = 1'b0;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    total++; if (Low !== 16'h0000) begin bad++; $display("FAIL reset_low got=%h exp=0000", Low); end
    total++; if (High !== 8'h00) begin bad++; $display("FAIL reset_high got=%h exp=00", High); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", out_err); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
    notRST = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    load_byte(8'hA5);   // OP = 5A
    load_byte(8'h3C);   // OP = C3, OPold = 5A
    req_valid = 1'b1; low_sel = 3'd3; high_sel = 1'b1; out_ready = 1'b1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%0b exp=1", req_ready); end
    tick();
    req_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
    total++; if (Low !== 16'hC35A) begin bad++; $display("FAIL basic_low got=%h exp=c35a", Low); end
    total++; if (High !== 8'hC3) begin bad++; $display("FAIL basic_high got=%h exp=c3", High); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%0b exp=0", out_err); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%0b exp=0", out_valid); end
    total++; if (Low !== 16'hC35A) begin bad++; $display("FAIL basic_hold_low got=%h exp=c35a", Low); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    req_valid = 1'b1; low_sel = 3'd1; high_sel = 1'b0;
    tick();
    low_sel = 3'd4;   // second request: {0, OPold} = 005A
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%0b exp=1", out_valid); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%0b exp=0", req_ready); end
    total++; if (Low !== 16'h00C3) begin bad++; $display("FAIL bp_low1 got=%h exp=00c3", Low); end
    tick();
    total++; if (Low !== 16'h00C3) begin bad++; $display("FAIL bp_low_held got=%h exp=00c3", Low); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_held got=%0b exp=0", req_ready); end
    out_ready = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_rise got=%0b exp=1", req_ready); end
    tick();
    req_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid2 got=%0b exp=1", out_valid); end
    total++; if (Low !== 16'h005A) begin bad++; $display("FAIL bp_low2 got=%h exp=005a", Low); end
    total++; if (High !== 8'h00) begin bad++; $display("FAIL bp_high2 got=%h exp=00", High); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
  endtask

  // Also covers back-to-back: one request per cycle, one result per cycle.
  task automatic test_back_to_back();
    logic [7:0]  nd   [5];
    logic [2:0]  sel  [5];
    logic [1:0]  idx  [5];
    logic [15:0] exp_low [5];
    nd = '{8'hEF, 8'hDE, 8'hAD, 8'hBE, 8'h0F};
    for (int i = 0; i < 5; i++) load_byte(nd[i]);
    // history now F0, 41, 52, 21
    sel     = '{3'd5,    3'd5,    3'd2,    3'd6,    3'd0};
    idx     = '{2'd3,    2'd0,    2'd0,    2'd1,    2'd0};
    exp_low = '{16'h0021, 16'h00F0, 16'hFFF0, 16'hF041, 16'h0000};
    out_ready = 1'b1; high_sel = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      low_sel = sel[i]; hist_idx = idx[i];
      tick();
      total++; if (out_valid !== 1'b1 || Low !== exp_low[i] || High !== 8'hF0 || out_err !== 1'b0) begin
        bad++; $display("FAIL b2b_%0d got v=%0b low=%h high=%h err=%0b exp v=1 low=%h high=f0 err=0",
                        i, out_valid, Low, High, out_err, exp_low[i]);
      end
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_same_cycle();
    load_byte(8'hED);   // OP = 12
    din_load = 1'b1; notDin = 8'h00;
    req_valid = 1'b1; low_sel = 3'd1; high_sel = 1'b0;
    tick();
    din_load = 1'b0;
    total++; if (Low !== 16'h0012) begin bad++; $display("FAIL same_pre got=%h exp=0012", Low); end
    tick();
    req_valid = 1'b0;
    total++; if (Low !== 16'h00FF) begin bad++; $display("FAIL same_post got=%h exp=00ff", Low); end
    tick();
  endtask

  task automatic test_illegal();
    // history (DEPTH=4): FF, 12, F0, 41 ; (DEPTH=3): FF, 12, F0
    req_valid = 1'b1; low_sel = 3'd7; high_sel = 1'b1;
    tick();
    total++; if (Low !== 16'h0000 || out_err !== 1'b1) begin bad++; $display("FAIL ill_sel7 got low=%h err=%0b exp low=0000 err=1", Low, out_err); end
    total++; if (High !== 8'hFF) begin bad++; $display("FAIL ill_high got=%h exp=ff", High); end
    low_sel = 3'd1;
    tick();
    total++; if (Low !== 16'h00FF || out_err !== 1'b0) begin bad++; $display("FAIL ill_clear got low=%h err=%0b exp low=00ff err=0", Low, out_err); end
    low_sel = 3'd5; hist_idx = 2'd3;
    tick();
    total++; if (Low !== 16'h0041 || out_err !== 1'b0) begin bad++; $display("FAIL ill_d4 got low=%h err=%0b exp low=0041 err=0", Low, out_err); end
    total++; if (Low3 !== 16'h0000 || out_err3 !== 1'b1) begin bad++; $display("FAIL ill_d3 got low=%h err=%0b exp low=0000 err=1", Low3, out_err3); end
    low_sel = 3'd6;
    tick();
    total++; if (Low3 !== 16'h0000 || out_err3 !== 1'b1 || High3 !== 8'hFF) begin bad++; $display("FAIL ill_d3_hop got low=%h err=%0b high=%h exp 0000 1 ff", Low3, out_err3, High3); end
    hist_idx = 2'd2;
    tick();
    req_valid = 1'b0;
    total++; if (Low3 !== 16'hFFF0 || out_err3 !== 1'b0) begin bad++; $display("FAIL ill_d3_ok got low=%h err=%0b exp fff0 0", Low3, out_err3); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    req_valid = 1'b1; low_sel = 3'd3; high_sel = 1'b1; hist_idx = 2'd0;
    tick();
    req_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || Low !== 16'hFF12) begin bad++; $display("FAIL rst_pre got v=%0b low=%h exp v=1 low=ff12", out_valid, Low); end
    #2 notRST = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || Low !== 16'h0000 || High !== 8'h00) begin bad++; $display("FAIL rst_async got v=%0b low=%h high=%h exp 0 0000 00", out_valid, Low, High); end
    tick();
    notRST = 1'b1; out_ready = 1'b1;
    req_valid = 1'b1; low_sel = 3'd6; hist_idx = 2'd3;
    tick();
    req_valid = 1'b0;
    total++; if (Low !== 16'h0000 || High !== 8'h00) begin bad++; $display("FAIL rst_hist got low=%h high=%h exp 0000 00", Low, High); end
  endtask

  task automatic test_clear();
    load_byte(8'h00);
    load_byte(8'h00);   // OP = OPold = FF
    hist_clr = 1'b1; din_load = 1'b1; notDin = 8'h00;
    req_valid = 1'b1; low_sel = 3'd3; high_sel = 1'b1;
    tick();
    hist_clr = 1'b0; din_load = 1'b0;
    total++; if (Low !== 16'hFFFF || High !== 8'hFF) begin bad++; $display("FAIL clr_pre got low=%h high=%h exp ffff ff", Low, High); end
    tick();
    total++; if (Low !== 16'h0000 || High !== 8'h00) begin bad++; $display("FAIL clr_post got low=%h high=%h exp 0000 00", Low, High); end
    low_sel = 3'd5; hist_idx = 2'd2;
    tick();
    req_valid = 1'b0;
    total++; if (Low !== 16'h0000) begin bad++; $display("FAIL clr_hist2 got=%h exp=0000", Low); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_same_cycle();
    test_illegal();
    test_reset_mid();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
